// File: rtl/traffic_light_ctrl.sv
// Intersection phase controller: steps NS/EW vehicle and walk lights on the
// watch's seconds strobe. Day/night mode picks the green length, and a
// level-sensitive emergency input holds every approach at red.
module traffic_light_ctrl #(
  parameter int unsigned DAY_GREEN   = 5,
  parameter int unsigned NIGHT_GREEN = 10,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned ALLRED_TIME = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       day_or_night,
  input  logic       emg,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ns_walk,
  output logic       ew_walk,
  output logic [2:0] phase,
  output logic [4:0] remaining
);

  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    EMERGENCY = 3'd6
  } state_t;

  localparam logic [4:0] T_DAY   = 5'(DAY_GREEN);
  localparam logic [4:0] T_NIGHT = 5'(NIGHT_GREEN);
  localparam logic [4:0] T_YEL   = 5'(YELLOW_TIME);
  localparam logic [4:0] T_AR    = 5'(ALLRED_TIME);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  state_t     state, state_nx;
  logic [4:0] rem, rem_nx;

  // Successor in the normal rotation.
  function automatic state_t seq_next(input state_t s);
    case (s)
      ALLRED_A:  seq_next = NS_GREEN;
      NS_GREEN:  seq_next = NS_YELLOW;
      NS_YELLOW: seq_next = ALLRED_B;
      ALLRED_B:  seq_next = EW_GREEN;
      EW_GREEN:  seq_next = EW_YELLOW;
      default:   seq_next = ALLRED_A;
    endcase
  endfunction

  // Duration loaded on entry; green length follows the mode at the entry edge.
  function automatic logic [4:0] dur(input state_t s, input logic night);
    case (s)
      NS_GREEN, EW_GREEN:   dur = night ? T_NIGHT : T_DAY;
      NS_YELLOW, EW_YELLOW: dur = T_YEL;
      EMERGENCY:            dur = 5'd0;
      default:              dur = T_AR;
    endcase
  endfunction

  // State and phase-timer register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ALLRED_A;
      rem   <= T_AR;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
    end
  end

  // Next state/timer: emergency first, then recovery, then tick-driven timing.
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    if (emg) begin
      state_nx = EMERGENCY;
      rem_nx   = 5'd0;
    end else begin
      case (state)
        EMERGENCY: begin
          state_nx = ALLRED_A;
          rem_nx   = T_AR;
        end
        ALLRED_A, NS_GREEN, NS_YELLOW, ALLRED_B, EW_GREEN, EW_YELLOW: begin
          if (sec_tick) begin
            if (rem > 5'd1) begin
              rem_nx = rem - 5'd1;
            end else begin
              // remaining of 0 in a timed phase can only come from an upset;
              // treat it as expired so the rotation never stalls.
              state_nx = seq_next(state);
              rem_nx   = dur(seq_next(state), day_or_night);
            end
          end
        end
        default: begin
          state_nx = ALLRED_A;
          rem_nx   = T_AR;
        end
      endcase
    end
  end

  // Light/walk decode from the registered state only.
  always_comb begin
    ns_light = RED;
    ew_light = RED;
    ns_walk  = 1'b0;
    ew_walk  = 1'b0;
    case (state)
      NS_GREEN: begin
        ns_light = GRN;
        ns_walk  = 1'b1;
      end
      NS_YELLOW: ns_light = YEL;
      EW_GREEN: begin
        ew_light = GRN;
        ew_walk  = 1'b1;
      end
      EW_YELLOW: ew_light = YEL;
      default: ;
    endcase
  end

  assign phase     = 3'(state);
  assign remaining = rem;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: a phase-sequence model pushes expected outputs
// at each edge, and they are popped and compared just after the edge.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0, sec_tick = 1'b0, day_or_night = 1'b0, emg = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic       ns_walk, ew_walk;
  logic [4:0] remaining;

  traffic_light_ctrl dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .day_or_night(day_or_night),
    .emg(emg), .ns_light(ns_light), .ew_light(ew_light), .ns_walk(ns_walk),
    .ew_walk(ew_walk), .phase(phase), .remaining(remaining)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [4:0] rem;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       nsw;
    logic       eww;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, passed = 0;
  bit   armed = 0;
  int   m_ph = 0, m_rem = 1;
  int   pcnt[8];

  // Phase order and durations as listed for the default parameters.
  function automatic int len_of(input int p, input logic night);
    case (p)
      1, 4:    len_of = night ? 10 : 5;
      2, 5:    len_of = 2;
      6:       len_of = 0;
      default: len_of = 1;
    endcase
  endfunction

  function automatic exp_t mk(input int p, input int r);
    exp_t e;
    e.ph = 3'(p); e.rem = 5'(r);
    e.ns = 3'b100; e.ew = 3'b100; e.nsw = 0; e.eww = 0;
    if (p == 1) begin e.ns = 3'b001; e.nsw = 1; end
    if (p == 2) e.ns = 3'b010;
    if (p == 4) begin e.ew = 3'b001; e.eww = 1; end
    if (p == 5) e.ew = 3'b010;
    return e;
  endfunction

  // One clock: drive tick, model the edge, then compare just after it.
  task automatic cyc(input logic t);
    exp_t e, got;
    sec_tick = t;
    @(posedge clk);
    if (rst) begin m_ph = 0; m_rem = 1; end
    else if (emg) begin m_ph = 6; m_rem = 0; end
    else if (m_ph == 6) begin m_ph = 0; m_rem = 1; end
    else if (t) begin
      if (m_rem > 1) m_rem--;
      else begin
        m_ph  = (m_ph == 5) ? 0 : m_ph + 1;
        m_rem = len_of(m_ph, day_or_night);
      end
    end
    sbq.push_back(mk(m_ph, m_rem));
    #1;
    sec_tick = 1'b0;
    got = {phase, remaining, ns_light, ew_light, ns_walk, ew_walk};
    checks++;
    if (sbq.size() == 0) $display("FAIL scoreboard_empty at %0t", $time);
    else begin
      e = sbq.pop_front();
      if (got !== e)
        $display("FAIL sb t=%0t got ph=%0d rem=%0d ns=%b ew=%b w=%b%b want ph=%0d rem=%0d ns=%b ew=%b w=%b%b",
                 $time, got.ph, got.rem, got.ns, got.ew, got.nsw, got.eww,
                 e.ph, e.rem, e.ns, e.ew, e.nsw, e.eww);
      else passed++;
    end
  endtask

  // One watch second: tick on one clock, then 9 quiet clocks.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      pcnt[phase]++;
      cyc(1'b1);
      for (int j = 0; j < 9; j++) cyc(1'b0);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) $display("FAIL %s got %0d want %0d", nm, got, want);
    else passed++;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 8; i++) pcnt[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; emg = 1'b0;
    cyc(1'b0);
    rst = 1'b0;
    armed = 1;
  endtask

  // Lights must be one-hot, never both non-red, walks never both on.
  always @(negedge clk) if (armed) begin
    checks++;
    if (!$onehot(ns_light) || !$onehot(ew_light) ||
        (ns_light != 3'b100 && ew_light != 3'b100) || (ns_walk && ew_walk))
      $display("FAIL safety t=%0t ns=%b ew=%b walks=%b%b want one-hot, one red, one walk max",
               $time, ns_light, ew_light, ns_walk, ew_walk);
    else passed++;
  end

  task automatic test_reset();
    do_reset();
    chk("reset_phase", phase, 0);
    chk("reset_rem", remaining, 1);
    chk("reset_ns", ns_light, 3'b100);
    chk("reset_ew", ew_light, 3'b100);
  endtask

  task automatic test_day_cycle();
    day_or_night = 0; do_reset(); clr_cnt();
    tick_n(16);
    chk("day_allred_a", pcnt[0], 1);
    chk("day_ns_green", pcnt[1], 5);
    chk("day_ns_yellow", pcnt[2], 2);
    chk("day_allred_b", pcnt[3], 1);
    chk("day_ew_green", pcnt[4], 5);
    chk("day_ew_yellow", pcnt[5], 2);
    chk("day_wrap_phase", phase, 0);
    chk("day_wrap_rem", remaining, 1);
  endtask

  task automatic test_night_cycle();
    day_or_night = 1; do_reset(); clr_cnt();
    tick_n(1);
    chk("night_ns_rem", remaining, 10);
    tick_n(25);
    chk("night_ns_green", pcnt[1], 10);
    chk("night_ew_green", pcnt[4], 10);
    chk("night_wrap_phase", phase, 0);
    chk("night_wrap_rem", remaining, 1);
    day_or_night = 0;
  endtask

  task automatic test_mode_switch();
    day_or_night = 0; do_reset();
    tick_n(3);
    chk("sw_ns_rem", remaining, 3);
    day_or_night = 1;
    tick_n(3);
    chk("sw_ns_done", phase, 2);
    tick_n(3);
    chk("sw_ew_phase", phase, 4);
    chk("sw_ew_rem", remaining, 10);
    tick_n(10);
    chk("sw_ew_done", phase, 5);
    day_or_night = 0;
  endtask

  task automatic test_emergency();
    day_or_night = 0; do_reset();
    tick_n(11);
    chk("emg_pre_phase", phase, 4);
    chk("emg_pre_rem", remaining, 3);
    emg = 1'b1;
    cyc(1'b1);
    chk("emg_phase", phase, 6);
    chk("emg_rem", remaining, 0);
    chk("emg_ns_red", ns_light, 3'b100);
    tick_n(5);
    chk("emg_hold_phase", phase, 6);
    chk("emg_hold_rem", remaining, 0);
    emg = 1'b0;
    cyc(1'b0);
    chk("emg_rel_phase", phase, 0);
    chk("emg_rel_rem", remaining, 1);
    tick_n(1);
    chk("emg_resume", phase, 1);
  endtask

  task automatic test_back_to_back();
    day_or_night = 0; do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1);
    chk("b2b5_phase", phase, 1);
    chk("b2b5_rem", remaining, 1);
    for (int i = 0; i < 3; i++) cyc(1'b1);
    chk("b2b8_phase", phase, 3);
    chk("b2b8_rem", remaining, 1);
  endtask

  task automatic test_mid_reset();
    day_or_night = 0; do_reset();
    tick_n(6);
    chk("mr_pre_phase", phase, 2);
    rst = 1'b1; emg = 1'b1;
    cyc(1'b1);
    rst = 1'b0; emg = 1'b0;
    chk("mr_phase", phase, 0);
    chk("mr_rem", remaining, 1);
    chk("mr_ns", ns_light, 3'b100);
    chk("mr_ew", ew_light, 3'b100);
    tick_n(2);
  endtask

  initial begin
    clr_cnt();
    @(negedge clk);
    test_reset();
    test_day_cycle();
    test_night_cycle();
    test_mode_switch();
    test_emergency();
    test_back_to_back();
    test_mid_reset();
    chk("sb_drained", sbq.size(), 0);
    armed = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
